alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
- Registered ALU control decoder for the single-cycle/pipelined 32-bit MIPS datapath.
- Maps the 2-bit alu_op from the main controller, plus the 6-bit R-type funct field, to the 3-bit ALU operation code consumed by the ALU.
- The output is registered, giving one cycle of latency, so the decode result aligns with the execute stage.
- Also flags R-type funct values it does not support.

Parameters:
- none (all widths fixed: alu_op 2, fnctn 6, alu_code 3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  alu_op/fnctn are valid this cycle
- alu_op  input  2  class from main controller: 00 mem/addi, 01 branch, 10 ori, 11 R-type
- fnctn  input  6  instruction funct field, bits [5:0]; used only when alu_op=11
- alu_code  output  3  registered ALU operation code
- out_valid  output  1  registered copy of in_valid
- illegal  output  1  registered; 1 when alu_op=11 and fnctn is unsupported

Behaviour:
- Clocking: single clock, all state on the rising edge of clk. Reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, alu_code=3'b010, out_valid=0, illegal=0. rst has priority over all other inputs.
- ALU code encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT. 101 is never produced.
- Decode for alu_op != 11 (fnctn ignored entirely):
  - 00 -> 010 (ADD)
  - 01 -> 110 (SUB)
  - 10 -> 001 (OR)
- Decode for alu_op = 11 (R-type, full 6-bit compare on fnctn):
  - 100000 -> 010 (ADD)
  - 100010 -> 110 (SUB)
  - 100100 -> 000 (AND)
  - 100101 -> 001 (OR)
  - 100110 -> 011 (XOR)
  - 100111 -> 100 (NOR)
  - 101010 -> 111 (SLT)
  - any other value -> 010 (ADD) with illegal=1
- illegal is 0 whenever alu_op != 11.
- Latency: inputs sampled at edge N appear on the outputs after edge N (one cycle). No combinational path from inputs to outputs.
- When in_valid=0, alu_code and illegal hold their previous values and out_valid becomes 0. When in_valid=1, all three outputs update.
- X/undefined alu_op is not handled; the design may produce any code in that case.
- No internal state other than the three output registers.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> alu_code=010, out_valid=0, illegal=0. Deassert with in_valid=1, alu_op=01 -> next cycle alu_code=110, out_valid=1.
- Non-R-type, fnctn ignored:
  - alu_op=00 with fnctn=011001 and 011111 -> 010
  - alu_op=01, fnctn=011111 -> 110
  - alu_op=10 with fnctn=011111 and 010101 -> 001
  - illegal=0 in all cases; each result appears one cycle after the input.
- R-type sweep, alu_op=11, illegal=0 for all:
  - fnctn 100000 -> 010
  - 100010 -> 110
  - 100110 -> 011
  - 100100 -> 000
  - 100101 -> 001
  - 100111 -> 100
  - 101010 -> 111
- Unsupported funct, alu_op=11: fnctn 000000, 100001, 111111 -> alu_code=010, illegal=1. Next cycle, alu_op=00 -> illegal=0.
- Hold: in_valid=1, alu_op=11, fnctn=100110 (alu_code=011). Then in_valid=0 with alu_op=01 for 3 cycles -> alu_code stays 011, out_valid=0.
- Reset mid-stream: back-to-back valid codes, assert rst on one edge -> that edge yields alu_code=010, out_valid=0. Decoding resumes on the first edge after rst falls.

Source files
------------

// File: rtl/alu_control_unit.sv
// Registered ALU control decoder for the 32-bit MIPS datapath.
// Maps alu_op/funct to a 3-bit ALU code and flags unsupported R-type funct values.
module alu_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] alu_op,
    input  logic [5:0] fnctn,
    output logic [2:0] alu_code,
    output logic       out_valid,
    output logic       illegal
);

    localparam logic [2:0] CODE_AND = 3'b000;
    localparam logic [2:0] CODE_OR  = 3'b001;
    localparam logic [2:0] CODE_ADD = 3'b010;
    localparam logic [2:0] CODE_XOR = 3'b011;
    localparam logic [2:0] CODE_NOR = 3'b100;
    localparam logic [2:0] CODE_SUB = 3'b110;
    localparam logic [2:0] CODE_SLT = 3'b111;

    logic [2:0] code_d, code_q;
    logic       illegal_d, illegal_q;
    logic       valid_q;

    // Decode the op class, and the funct field for R-type instructions
    always_comb begin
        code_d    = CODE_ADD;
        illegal_d = 1'b0;
        unique case (alu_op)
            2'b00: code_d = CODE_ADD;
            2'b01: code_d = CODE_SUB;
            2'b10: code_d = CODE_OR;
            2'b11: begin
                unique case (fnctn)
                    6'b100000: code_d = CODE_ADD;
                    6'b100010: code_d = CODE_SUB;
                    6'b100100: code_d = CODE_AND;
                    6'b100101: code_d = CODE_OR;
                    6'b100110: code_d = CODE_XOR;
                    6'b100111: code_d = CODE_NOR;
                    6'b101010: code_d = CODE_SLT;
                    default: begin
                        code_d    = CODE_ADD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: code_d = CODE_ADD;
        endcase
    end

    // Output registers: code/illegal update only on valid input, valid always follows
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q    <= CODE_ADD;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                code_q    <= code_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign alu_code  = code_q;
    assign illegal   = illegal_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed cases plus
// randomized stimulus compared against a table-driven reference model.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] alu_op;
    logic [5:0] fnctn;
    logic [2:0] alu_code;
    logic       out_valid;
    logic       illegal;

    int checks = 0;
    int failures = 0;

    // Expected output state
    int exp_code;
    int exp_ill;
    int exp_vld;

    // Supported R-type funct values and their ALU codes
    int rt_fn[7]   = '{32, 34, 36, 37, 38, 39, 42};
    int rt_code[7] = '{2, 6, 0, 1, 3, 4, 7};

    alu_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .alu_op   (alu_op),
        .fnctn    (fnctn),
        .alu_code (alu_code),
        .out_valid(out_valid),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: op class gives the code directly; R-type looks up the table
    task automatic ref_decode(input int op, input int fn,
                              output int code, output int ill);
        code = 2;
        ill  = 0;
        if (op == 0) code = 2;
        else if (op == 1) code = 6;
        else if (op == 2) code = 1;
        else begin
            ill = 1;
            for (int i = 0; i < 7; i++)
                if (rt_fn[i] == fn) begin
                    code = rt_code[i];
                    ill  = 0;
                end
        end
    endtask

    // Apply one cycle of inputs, advance the model, check outputs after the edge
    task automatic step(input string tag, input bit r, input bit v,
                        input int op, input int fn);
        int c, il;
        rst      = r;
        in_valid = v;
        alu_op   = 2'(op);
        fnctn    = 6'(fn);
        @(posedge clk);
        #1;
        if (r) begin
            exp_code = 2;
            exp_ill  = 0;
            exp_vld  = 0;
        end else begin
            exp_vld = v ? 1 : 0;
            if (v) begin
                ref_decode(op, fn, c, il);
                exp_code = c;
                exp_ill  = il;
            end
        end
        chk({tag, ".code"}, int'(alu_code), exp_code);
        chk({tag, ".vld"}, int'(out_valid), exp_vld);
        chk({tag, ".ill"}, int'(illegal), exp_ill);
    endtask

    initial begin
        int op, fn;
        rst = 1'b1;
        in_valid = 1'b0;
        alu_op = '0;
        fnctn = '0;
        exp_code = 2;
        exp_ill = 0;
        exp_vld = 0;

        // Reset with arbitrary inputs
        step("rst0", 1, 1, 3, 6'b000000);
        step("rst1", 1, 1, 1, 6'b111111);
        step("post_rst", 0, 1, 1, 0);
        chk("post_rst_sub", int'(alu_code), 6);

        // Non-R-type ignores funct
        step("op00a", 0, 1, 0, 6'b011001);
        step("op00b", 0, 1, 0, 6'b011111);
        step("op01", 0, 1, 1, 6'b011111);
        step("op10a", 0, 1, 2, 6'b011111);
        step("op10b", 0, 1, 2, 6'b010101);

        // R-type sweep
        step("r_add", 0, 1, 3, 6'b100000);
        chk("r_add_lit", int'(alu_code), 2);
        step("r_sub", 0, 1, 3, 6'b100010);
        chk("r_sub_lit", int'(alu_code), 6);
        step("r_xor", 0, 1, 3, 6'b100110);
        chk("r_xor_lit", int'(alu_code), 3);
        step("r_and", 0, 1, 3, 6'b100100);
        chk("r_and_lit", int'(alu_code), 0);
        step("r_or", 0, 1, 3, 6'b100101);
        chk("r_or_lit", int'(alu_code), 1);
        step("r_nor", 0, 1, 3, 6'b100111);
        chk("r_nor_lit", int'(alu_code), 4);
        step("r_slt", 0, 1, 3, 6'b101010);
        chk("r_slt_lit", int'(alu_code), 7);

        // Unsupported funct
        step("bad0", 0, 1, 3, 6'b000000);
        chk("bad0_lit", int'(illegal), 1);
        step("bad1", 0, 1, 3, 6'b100001);
        step("bad2", 0, 1, 3, 6'b111111);
        step("bad_clr", 0, 1, 0, 6'b111111);
        chk("bad_clr_lit", int'(illegal), 0);

        // Hold while in_valid is low
        step("hold_set", 0, 1, 3, 6'b100110);
        step("hold1", 0, 0, 1, 0);
        step("hold2", 0, 0, 1, 0);
        step("hold3", 0, 0, 1, 0);
        chk("hold_lit", int'(alu_code), 3);

        // Reset mid-stream
        step("ms0", 0, 1, 3, 6'b101010);
        step("ms1", 0, 1, 1, 0);
        step("ms_rst", 1, 1, 3, 6'b100100);
        step("ms_resume", 0, 1, 3, 6'b100100);

        // Random stimulus, biased toward supported R-type funct values
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                fn = rt_fn[$urandom_range(0, 6)];
            else
                fn = int'($urandom_range(0, 63));
            step("rnd", ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), op, fn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
